// File: rtl/mem_pkg.sv
// Shared encodings for the MEM stage: access widths, debug-read FSM states
// and the alignment rule used for both loads and stores.
package mem_pkg;

  localparam logic [1:0] W_BYTE = 2'b00;
  localparam logic [1:0] W_HALF = 2'b01;
  localparam logic [1:0] W_WORD = 2'b11;

  typedef enum logic [1:0] {
    D_IDLE = 2'b00,
    D_READ = 2'b01,
    D_DONE = 2'b10
  } dbg_state_e;

  // Encoding 2'b10 falls into the default arm and is treated as a word access.
  function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] lane);
    case (width)
      W_BYTE:  return 1'b0;
      W_HALF:  return lane[0];
      default: return |lane;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_data_memory.sv
// Word-organised data RAM: byte-enabled write, registered read-before-write
// read port, combinational debug read port, cleared on reset.
module data_memory #(
  parameter int DATA_SIZE = 32,
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = $clog2(MEM_DEPTH)
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic [3:0]           i_we,
  input  logic [ADDR_SIZE-1:0] i_addr,
  input  logic [DATA_SIZE-1:0] i_wdata,
  input  logic                 i_re,
  output logic [DATA_SIZE-1:0] o_rdata,
  input  logic [ADDR_SIZE-1:0] i_dbg_addr,
  output logic [DATA_SIZE-1:0] o_dbg_data
);

  logic [DATA_SIZE-1:0] mem_q [MEM_DEPTH];
  logic [DATA_SIZE-1:0] rdata_d, rdata_q;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    rdata_d = rdata_q;
    if (i_re) rdata_d = mem_q[i_addr];
  end

  // NOTE: the array is cleared on reset because software relies on zeroed data
  // memory; this rules out a plain block RAM macro for this storage.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
      rdata_q <= '0;
    end else begin
      // NOTE: non-blocking writes make the same-edge read return the old word.
      for (int b = 0; b < 4; b++)
        if (i_we[b]) mem_q[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      rdata_q <= rdata_d;
    end
  end

  assign o_rdata    = rdata_q;
  assign o_dbg_data = mem_q[i_dbg_addr];

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: lane steering and load extension around data_memory,
// misalignment detection, debug word-read FSM and MEM_WB passthroughs.
module mem_stage
  import mem_pkg::*;
#(
  parameter int DATA_SIZE = 32,
  parameter int REG_SIZE  = 5,
  parameter int PC_SIZE   = 32,
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = $clog2(MEM_DEPTH)
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_pipeline_enable,
  input  logic                 i_mem_read,
  input  logic                 i_mem_write,
  input  logic [1:0]           i_width,
  input  logic                 i_unsigned,
  input  logic [DATA_SIZE-1:0] i_alu_result,
  input  logic [DATA_SIZE-1:0] i_write_data,
  input  logic                 i_reg_write,
  input  logic                 i_mem_to_reg,
  input  logic                 i_last_register_ctrl,
  input  logic                 i_halt,
  input  logic [REG_SIZE-1:0]  i_selected_reg,
  input  logic [PC_SIZE-1:0]   i_pc,
  input  logic                 i_debug_req,
  input  logic [ADDR_SIZE-1:0] i_debug_addr,
  output logic [DATA_SIZE-1:0] o_mem_data,
  output logic                 o_misaligned,
  output logic [DATA_SIZE-1:0] o_debug_data,
  output logic                 o_debug_valid,
  output logic                 o_reg_write,
  output logic                 o_mem_to_reg,
  output logic [DATA_SIZE-1:0] o_alu_result,
  output logic [REG_SIZE-1:0]  o_selected_reg,
  output logic                 o_last_register_ctrl,
  output logic [PC_SIZE-1:0]   o_pc,
  output logic                 o_halt
);

  logic [ADDR_SIZE-1:0] word_idx;
  logic [1:0]           lane;
  logic                 access_mis, store_fire, load_fire;
  logic [3:0]           we;
  logic [DATA_SIZE-1:0] wdata, rd_word, dbg_word;

  assign word_idx   = i_alu_result[ADDR_SIZE+1:2];
  assign lane       = i_alu_result[1:0];
  assign access_mis = is_misaligned(i_width, lane);
  assign store_fire = i_pipeline_enable & i_mem_write & ~access_mis;
  assign load_fire  = i_pipeline_enable & i_mem_read & ~i_mem_write;

  always_comb begin
    we    = 4'b0000;
    wdata = i_write_data;
    case (i_width)
      W_BYTE: begin
        we    = 4'b0001 << lane;
        wdata = {4{i_write_data[7:0]}};
      end
      W_HALF: begin
        we    = lane[1] ? 4'b1100 : 4'b0011;
        wdata = {2{i_write_data[15:0]}};
      end
      default: we = 4'b1111;
    endcase
    if (!store_fire) we = 4'b0000;
  end

  // Load lane/width/sign info is captured alongside the registered RAM read
  // so the extension can be applied to the word that comes out next cycle.
  logic [1:0]  ld_lane_d, ld_lane_q, ld_width_d, ld_width_q;
  logic        ld_uns_d, ld_uns_q, ld_zero_d, ld_zero_q;
  logic        mis_d, mis_q;
  dbg_state_e  dbg_state_d, dbg_state_q;
  logic [ADDR_SIZE-1:0] dbg_addr_d, dbg_addr_q;
  logic [DATA_SIZE-1:0] dbg_data_d, dbg_data_q;
  logic                 dbg_valid_d, dbg_valid_q;

  data_memory #(
    .DATA_SIZE(DATA_SIZE), .MEM_DEPTH(MEM_DEPTH), .ADDR_SIZE(ADDR_SIZE)
  ) u_dmem (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_we      (we),
    .i_addr    (word_idx),
    .i_wdata   (wdata),
    .i_re      (load_fire),
    .o_rdata   (rd_word),
    .i_dbg_addr(dbg_addr_q),
    .o_dbg_data(dbg_word)
  );

  always_comb begin
    ld_lane_d  = ld_lane_q;
    ld_width_d = ld_width_q;
    ld_uns_d   = ld_uns_q;
    ld_zero_d  = ld_zero_q;
    if (load_fire) begin
      ld_lane_d  = lane;
      ld_width_d = i_width;
      ld_uns_d   = i_unsigned;
      ld_zero_d  = access_mis;
    end
    mis_d = i_pipeline_enable & (i_mem_read | i_mem_write) & access_mis;
  end

  always_comb begin
    dbg_state_d = dbg_state_q;
    dbg_addr_d  = dbg_addr_q;
    dbg_data_d  = dbg_data_q;
    dbg_valid_d = dbg_valid_q;
    case (dbg_state_q)
      D_IDLE: if (i_debug_req && !i_pipeline_enable) begin
        dbg_state_d = D_READ;
        dbg_addr_d  = i_debug_addr;
      end
      D_READ: begin
        if (i_pipeline_enable) begin
          dbg_state_d = D_IDLE;
        end else begin
          dbg_state_d = D_DONE;
          dbg_data_d  = dbg_word;
          dbg_valid_d = 1'b1;
        end
      end
      D_DONE: if (!i_debug_req) begin
        dbg_state_d = D_IDLE;
        dbg_valid_d = 1'b0;
      end
      default: begin
        dbg_state_d = D_IDLE;
        dbg_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      ld_lane_q   <= 2'b00;
      ld_width_q  <= W_WORD;
      ld_uns_q    <= 1'b0;
      ld_zero_q   <= 1'b0;
      mis_q       <= 1'b0;
      dbg_state_q <= D_IDLE;
      dbg_addr_q  <= '0;
      dbg_data_q  <= '0;
      dbg_valid_q <= 1'b0;
    end else begin
      ld_lane_q   <= ld_lane_d;
      ld_width_q  <= ld_width_d;
      ld_uns_q    <= ld_uns_d;
      ld_zero_q   <= ld_zero_d;
      mis_q       <= mis_d;
      dbg_state_q <= dbg_state_d;
      dbg_addr_q  <= dbg_addr_d;
      dbg_data_q  <= dbg_data_d;
      dbg_valid_q <= dbg_valid_d;
    end
  end

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte   = rd_word[{ld_lane_q, 3'b000} +: 8];
    sel_half   = ld_lane_q[1] ? rd_word[31:16] : rd_word[15:0];
    o_mem_data = rd_word;
    case (ld_width_q)
      W_BYTE:  o_mem_data = {{(DATA_SIZE-8){~ld_uns_q & sel_byte[7]}}, sel_byte};
      W_HALF:  o_mem_data = {{(DATA_SIZE-16){~ld_uns_q & sel_half[15]}}, sel_half};
      default: o_mem_data = rd_word;
    endcase
    if (ld_zero_q) o_mem_data = '0;
  end

  assign o_misaligned         = mis_q;
  assign o_debug_data         = dbg_data_q;
  assign o_debug_valid        = dbg_valid_q;
  assign o_reg_write          = i_reg_write;
  assign o_mem_to_reg         = i_mem_to_reg;
  assign o_alu_result         = i_alu_result;
  assign o_selected_reg       = i_selected_reg;
  assign o_last_register_ctrl = i_last_register_ctrl;
  assign o_pc                 = i_pc;
  assign o_halt               = i_halt;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: table of load/store vectors with hand-computed
// results, plus sequences for debug reads, debug abort and reset.
module tb_mem_stage;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        i_reset, i_pipeline_enable, i_mem_read, i_mem_write, i_unsigned;
  logic [1:0]  i_width;
  logic [31:0] i_alu_result, i_write_data, i_pc;
  logic        i_reg_write, i_mem_to_reg, i_last_register_ctrl, i_halt;
  logic [4:0]  i_selected_reg;
  logic        i_debug_req;
  logic [7:0]  i_debug_addr;
  logic [31:0] o_mem_data, o_debug_data, o_alu_result, o_pc;
  logic        o_misaligned, o_debug_valid, o_reg_write, o_mem_to_reg;
  logic        o_last_register_ctrl, o_halt;
  logic [4:0]  o_selected_reg;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .i_clock(clk), .i_reset(i_reset), .i_pipeline_enable(i_pipeline_enable),
    .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_width(i_width),
    .i_unsigned(i_unsigned), .i_alu_result(i_alu_result), .i_write_data(i_write_data),
    .i_reg_write(i_reg_write), .i_mem_to_reg(i_mem_to_reg),
    .i_last_register_ctrl(i_last_register_ctrl), .i_halt(i_halt),
    .i_selected_reg(i_selected_reg), .i_pc(i_pc), .i_debug_req(i_debug_req),
    .i_debug_addr(i_debug_addr), .o_mem_data(o_mem_data), .o_misaligned(o_misaligned),
    .o_debug_data(o_debug_data), .o_debug_valid(o_debug_valid),
    .o_reg_write(o_reg_write), .o_mem_to_reg(o_mem_to_reg), .o_alu_result(o_alu_result),
    .o_selected_reg(o_selected_reg), .o_last_register_ctrl(o_last_register_ctrl),
    .o_pc(o_pc), .o_halt(o_halt)
  );

  typedef struct {
    string       name;
    logic        en, rd, wr, uns;
    logic [1:0]  width;
    logic [31:0] addr, wdata, exp_data;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic add(input string name, input logic en, input logic rd, input logic wr,
                     input logic [1:0] width, input logic uns, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp_data, input logic exp_mis);
    vec_t v;
    v.name = name; v.en = en; v.rd = rd; v.wr = wr; v.width = width; v.uns = uns;
    v.addr = addr; v.wdata = wdata; v.exp_data = exp_data; v.exp_mis = exp_mis;
    vecs.push_back(v);
  endtask

  task automatic idle_bus();
    i_mem_read = 0; i_mem_write = 0; i_width = W_WORD; i_unsigned = 0;
    i_alu_result = 0; i_write_data = 0;
  endtask

  initial begin
    i_reset = 0; i_pipeline_enable = 1; i_debug_req = 0; i_debug_addr = 0;
    i_reg_write = 0; i_mem_to_reg = 0; i_last_register_ctrl = 0; i_halt = 0;
    i_selected_reg = 0; i_pc = 0;
    idle_bus();

    add("sw_deadbeef", 1, 0, 1, W_WORD, 0, 32'h10,  32'hDEADBEEF, 32'h0,        0);
    add("lb_s_13",     1, 1, 0, W_BYTE, 0, 32'h13,  32'h0,        32'hFFFFFFDE, 0);
    add("lbu_13",      1, 1, 0, W_BYTE, 1, 32'h13,  32'h0,        32'h000000DE, 0);
    add("sh_8001",     1, 0, 1, W_HALF, 0, 32'h22,  32'h00008001, 32'h000000DE, 0);
    add("lh_s_22",     1, 1, 0, W_HALF, 0, 32'h22,  32'h0,        32'hFFFF8001, 0);
    add("lw_20",       1, 1, 0, W_WORD, 0, 32'h20,  32'h0,        32'h80010000, 0);
    add("lhu_10",      1, 1, 0, W_HALF, 1, 32'h10,  32'h0,        32'h0000BEEF, 0);
    add("lb_s_11",     1, 1, 0, W_BYTE, 0, 32'h11,  32'h0,        32'hFFFFFFBE, 0);
    add("sw_mis_06",   1, 0, 1, W_WORD, 0, 32'h06,  32'h12345678, 32'hFFFFFFBE, 1);
    add("lw_04",       1, 1, 0, W_WORD, 0, 32'h04,  32'h0,        32'h00000000, 0);
    add("lb_s_12",     1, 1, 0, W_BYTE, 0, 32'h12,  32'h0,        32'hFFFFFFAD, 0);
    add("lh_mis_21",   1, 1, 0, W_HALF, 0, 32'h21,  32'h0,        32'h00000000, 1);
    add("nop_pulse",   1, 0, 0, W_WORD, 0, 32'h0,   32'h0,        32'h00000000, 0);
    add("sb_401",      1, 0, 1, W_BYTE, 0, 32'h401, 32'h555555AA, 32'h00000000, 0);
    add("lw_000",      1, 1, 0, W_WORD, 0, 32'h0,   32'h0,        32'h0000AA00, 0);
    add("lw_400",      1, 1, 0, W_WORD, 0, 32'h400, 32'h0,        32'h0000AA00, 0);
    add("sw_frozen",   0, 0, 1, W_WORD, 0, 32'h30,  32'h11223344, 32'h0000AA00, 0);
    add("lw_frozen",   0, 1, 0, W_WORD, 0, 32'h30,  32'h0,        32'h0000AA00, 0);
    add("lw_30",       1, 1, 0, W_WORD, 0, 32'h30,  32'h0,        32'h00000000, 0);
    add("lb_s_10",     1, 1, 0, W_BYTE, 0, 32'h10,  32'h0,        32'hFFFFFFEF, 0);
    add("rw_both",     1, 1, 1, W_WORD, 0, 32'h30,  32'hCAFEF00D, 32'hFFFFFFEF, 0);
    add("lw_w10_30",   1, 1, 0, 2'b10,  0, 32'h30,  32'h0,        32'hCAFEF00D, 0);
    add("lh_mis_w10",  1, 1, 0, 2'b10,  0, 32'h32,  32'h0,        32'h00000000, 1);
    add("lhu_32",      1, 1, 0, W_HALF, 1, 32'h32,  32'h0,        32'h0000CAFE, 0);

    @(negedge clk);
    step(); step();
    check("rst_mem_data", o_mem_data, 32'h0);
    check("rst_mis", {31'b0, o_misaligned}, 32'h0);
    check("rst_dbg_data", o_debug_data, 32'h0);
    check("rst_dbg_valid", {31'b0, o_debug_valid}, 32'h0);
    i_reset = 1;

    foreach (vecs[i]) begin
      i_pipeline_enable = vecs[i].en; i_mem_read = vecs[i].rd; i_mem_write = vecs[i].wr;
      i_width = vecs[i].width; i_unsigned = vecs[i].uns;
      i_alu_result = vecs[i].addr; i_write_data = vecs[i].wdata;
      step();
      check({vecs[i].name, "_data"}, o_mem_data, vecs[i].exp_data);
      check({vecs[i].name, "_mis"}, {31'b0, o_misaligned}, {31'b0, vecs[i].exp_mis});
    end
    idle_bus();

    for (int k = 0; k < 3; k++) begin
      i_reg_write = k[0]; i_mem_to_reg = ~k[0]; i_last_register_ctrl = k[1]; i_halt = ~k[1];
      i_selected_reg = 5'(7 * k + 3); i_pc = 32'h0040_0000 + 32'(k * 4);
      i_alu_result = 32'hA5A5_0000 ^ 32'(k);
      #1;
      check("pass_ctrl", {28'b0, o_reg_write, o_mem_to_reg, o_last_register_ctrl, o_halt},
            {28'b0, k[0], ~k[0], k[1], ~k[1]});
      check("pass_data", o_pc ^ {27'b0, o_selected_reg},
            (32'h0040_0000 + 32'(k * 4)) ^ 32'(7 * k + 3));
      check("pass_alu", o_alu_result, 32'hA5A5_0000 ^ 32'(k));
    end
    i_alu_result = 0;

    // Debug read of word 4 (byte 0x10) while frozen.
    @(negedge clk);
    i_pipeline_enable = 0; i_debug_req = 1; i_debug_addr = 8'd4;
    step();
    check("dbg_e1_valid", {31'b0, o_debug_valid}, 32'h0);
    step();
    check("dbg_e2_valid", {31'b0, o_debug_valid}, 32'h1);
    check("dbg_e2_data", o_debug_data, 32'hDEADBEEF);
    step();
    check("dbg_hold_valid", {31'b0, o_debug_valid}, 32'h1);
    i_debug_req = 0;
    step();
    check("dbg_drop_valid", {31'b0, o_debug_valid}, 32'h0);

    // Abort in D_READ, then wait while enabled, then complete on word 8.
    i_debug_req = 1; i_debug_addr = 8'd8;
    step();
    i_pipeline_enable = 1;
    step();
    check("dbg_abort_valid", {31'b0, o_debug_valid}, 32'h0);
    step();
    check("dbg_wait_valid", {31'b0, o_debug_valid}, 32'h0);
    i_pipeline_enable = 0;
    step(); step();
    check("dbg_retry_valid", {31'b0, o_debug_valid}, 32'h1);
    check("dbg_retry_data", o_debug_data, 32'h80010000);
    i_debug_req = 0;
    step();

    // Load something nonzero, then reset in the middle of a debug read.
    i_pipeline_enable = 1; i_mem_read = 1; i_alu_result = 32'h30;
    step();
    check("pre_rst_load", o_mem_data, 32'hCAFEF00D);
    idle_bus();
    i_pipeline_enable = 0; i_debug_req = 1; i_debug_addr = 8'd4;
    step();
    i_reset = 0;
    step();
    check("mid_rst_dbg_valid", {31'b0, o_debug_valid}, 32'h0);
    check("mid_rst_dbg_data", o_debug_data, 32'h0);
    check("mid_rst_mem_data", o_mem_data, 32'h0);
    check("mid_rst_mis", {31'b0, o_misaligned}, 32'h0);
    i_reset = 1; i_debug_req = 0;
    step();
    check("post_rst_valid", {31'b0, o_debug_valid}, 32'h0);
    i_pipeline_enable = 1; i_mem_read = 1; i_alu_result = 32'h10;
    step();
    check("post_rst_lw_10", o_mem_data, 32'h0);
    i_alu_result = 32'h30;
    step();
    check("post_rst_lw_30", o_mem_data, 32'h0);
    idle_bus();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
